// File: rtl/result_page_reader_if.sv
// result_page_reader_if: page request, shared BRAM read port and 64-bit output stream.
interface result_page_reader_if;
    logic          start;
    logic [16:0]   page_len;
    logic          rd_en;
    logic [8:0]    rd_address;
    logic [1023:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [7:0]    out_keep;
    logic          out_last;
    logic          block_out_finish;
    logic          busy;
    modport master (
        input  start, page_len, rd_data, out_ready,
        output rd_en, rd_address, out_valid, out_data, out_keep, out_last, block_out_finish, busy
    );
    modport slave (
        output start, page_len, rd_data, out_ready,
        input  rd_en, rd_address, out_valid, out_data, out_keep, out_last, block_out_finish, busy
    );
endinterface

// File: rtl/result_page_reader.sv
// result_page_reader: sweeps the interleaved result BRAMs in word order and streams the page out.
module result_page_reader #(
    parameter int NUM_BLOCKS = 16,
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    result_page_reader_if.master bus
);
    localparam int BW = $clog2(NUM_BLOCKS);
    localparam int WW = ADDR_W + BW;
    localparam int LW = WW + 4;
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;
    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;
    state_t        state, state_nx;
    logic [LW-1:0] len_q;
    logic [WW:0]   nwords;
    logic [WW-1:0] w;
    logic [BW-1:0] tag_blk;
    logic          tag_v, tag_last, issue, last_w, push, pop;
    logic [7:0]    keep_last;
    beat_t         mem [FIFO_DEPTH];
    beat_t         head, beat;
    logic [PW-1:0] wp, rp;
    logic [PW:0]   count;
    assign nwords    = (WW+1)'((len_q + LW'(7)) >> 3);
    assign last_w    = ({1'b0, w} == nwords - 1'b1);
    assign keep_last = (len_q[2:0] == 3'd0) ? 8'hff : ~(8'hff << len_q[2:0]);
    // Reserve FIFO space for the read still in the BRAM pipe so a stall never overflows it.
    assign issue     = (state == READ) && (({1'b0, count} + (PW+2)'(tag_v)) < (PW+2)'(FIFO_DEPTH));
    assign push      = tag_v;
    assign pop       = bus.out_valid && bus.out_ready;
    assign head      = mem[rp];
    assign beat      = '{last: tag_last, keep: tag_last ? keep_last : 8'hff, data: bus.rd_data[64*tag_blk +: 64]};
    always_comb begin
        state_nx             = state;
        bus.rd_en            = issue;
        bus.rd_address       = w[WW-1:BW];
        bus.out_valid        = (count != '0);
        bus.out_data         = bus.out_valid ? head.data : '0;
        bus.out_keep         = bus.out_valid ? head.keep : '0;
        bus.out_last         = bus.out_valid && head.last;
        bus.block_out_finish = (state == FINISH);
        bus.busy             = (state != IDLE);
        unique case (state)
            IDLE:   if (bus.start) state_nx = (bus.page_len == '0) ? FINISH : READ;
            READ:   if (issue && last_w) state_nx = DRAIN;
            DRAIN:  if (pop && head.last) state_nx = FINISH;
            FINISH: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            w        <= '0;
            tag_v    <= 1'b0;
            tag_last <= 1'b0;
            tag_blk  <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            if (state == IDLE && bus.start) begin
                len_q <= bus.page_len;
                w     <= '0;
            end else if (issue) begin
                w <= w + 1'b1;
            end
            tag_v    <= issue;
            tag_last <= last_w;
            tag_blk  <= w[BW-1:0];
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count    <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= beat;
    end
endmodule
